// File: rtl/data_memory_responder.sv
// Multi-cycle word-addressed data memory answering the cache's start/finish
// handshake with programmable read and write latency and protocol checking.
module data_memory_responder #(
   parameter int MEM_DEPTH_LOG2 = 10,
   parameter int READ_LATENCY   = 4,
   parameter int WRITE_LATENCY  = 4
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        MemReadStart,
   input  logic [31:0] MemReadAddr,
   output logic [31:0] MemReadData,
   output logic        MemReadFinish,
   input  logic        MemWriteStart,
   input  logic [31:0] MemWriteAddr,
   input  logic [31:0] MemWriteData,
   output logic        MemWriteFinish,
   output logic        Busy,
   output logic        ProtocolError
);

   localparam int AW = MEM_DEPTH_LOG2;
   localparam logic [7:0] RD_CNT = 8'(READ_LATENCY - 1);
   localparam logic [7:0] WR_CNT = 8'(WRITE_LATENCY - 1);

   typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT} state_t;

   logic [31:0] mem [0:(1<<AW)-1];

   state_t        state_q, state_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          rd_start_q, rd_start_d, wr_start_q, wr_start_d;
   logic          rd_pend_q, rd_pend_d, wr_pend_q, wr_pend_d;
   logic [AW-1:0] rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
   logic [31:0]   wr_data_q, wr_data_d;
   logic [31:0]   rd_data_q, rd_data_d;
   logic          rd_fin_q, rd_fin_d, wr_fin_q, wr_fin_d;
   logic          err_q, err_d;
   logic          mem_we;

   logic rd_req, wr_req, rd_acc, wr_acc;

   // Address bits outside the word index are intentionally ignored (aliasing).
   logic unused_addr_bits;
   assign unused_addr_bits = ^{MemReadAddr[31:AW+2], MemReadAddr[1:0],
                               MemWriteAddr[31:AW+2], MemWriteAddr[1:0]};

   assign rd_req = MemReadStart  & ~rd_start_q;
   assign wr_req = MemWriteStart & ~wr_start_q;
   // A request is accepted only if its type has a free slot: neither pending nor in service.
   assign rd_acc = rd_req & ~rd_pend_q & (state_q != READ_WAIT);
   assign wr_acc = wr_req & ~wr_pend_q & (state_q != WRITE_WAIT);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rd_start_d = MemReadStart;
      wr_start_d = MemWriteStart;
      rd_pend_d  = rd_pend_q;
      wr_pend_d  = wr_pend_q;
      rd_idx_d   = rd_idx_q;
      wr_idx_d   = wr_idx_q;
      wr_data_d  = wr_data_q;
      rd_data_d  = rd_data_q;
      rd_fin_d   = 1'b0;
      wr_fin_d   = 1'b0;
      err_d      = err_q;
      mem_we     = 1'b0;

      if (rd_acc) begin
         rd_idx_d  = MemReadAddr[AW+1:2];
         rd_pend_d = 1'b1;
      end
      if (wr_acc) begin
         wr_idx_d  = MemWriteAddr[AW+1:2];
         wr_data_d = MemWriteData;
         wr_pend_d = 1'b1;
      end
      if ((rd_req & ~rd_acc) | (wr_req & ~wr_acc))
         err_d = 1'b1;

      case (state_q)
         IDLE: begin
            // Write first so a dirty write-back lands before the refill read.
            if (wr_acc | wr_pend_q) begin
               state_d   = WRITE_WAIT;
               cnt_d     = WR_CNT;
               wr_pend_d = 1'b0;
            end else if (rd_acc | rd_pend_q) begin
               state_d   = READ_WAIT;
               cnt_d     = RD_CNT;
               rd_pend_d = 1'b0;
            end
         end
         READ_WAIT: begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd0) begin
               rd_data_d = mem[rd_idx_q];
               rd_fin_d  = 1'b1;
               cnt_d     = 8'd0;
               state_d   = IDLE;
            end
         end
         WRITE_WAIT: begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd0) begin
               mem_we   = 1'b1;
               wr_fin_d = 1'b1;
               cnt_d    = 8'd0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q    <= IDLE;
         cnt_q      <= 8'd0;
         rd_start_q <= 1'b0;
         wr_start_q <= 1'b0;
         rd_pend_q  <= 1'b0;
         wr_pend_q  <= 1'b0;
         rd_idx_q   <= '0;
         wr_idx_q   <= '0;
         wr_data_q  <= 32'd0;
         rd_data_q  <= 32'd0;
         rd_fin_q   <= 1'b0;
         wr_fin_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rd_start_q <= rd_start_d;
         wr_start_q <= wr_start_d;
         rd_pend_q  <= rd_pend_d;
         wr_pend_q  <= wr_pend_d;
         rd_idx_q   <= rd_idx_d;
         wr_idx_q   <= wr_idx_d;
         wr_data_q  <= wr_data_d;
         rd_data_q  <= rd_data_d;
         rd_fin_q   <= rd_fin_d;
         wr_fin_q   <= wr_fin_d;
         err_q      <= err_d;
      end
   end

   // Array contents survive reset; a write aborted by reset never reaches here.
   always_ff @(posedge CLK) begin
      if (mem_we)
         mem[wr_idx_q] <= wr_data_q;
   end

   assign MemReadData    = rd_data_q;
   assign MemReadFinish  = rd_fin_q;
   assign MemWriteFinish = wr_fin_q;
   assign ProtocolError  = err_q;
   assign Busy           = (state_q != IDLE) | rd_pend_q | wr_pend_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: expected finish cycle and read
// data are queued when a request is driven and checked when Finish pulses.
module tb_data_memory_responder;

   localparam int RL = 4;
   localparam int WL = 4;

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        Reset;
   logic        MemReadStart, MemWriteStart;
   logic [31:0] MemReadAddr, MemWriteAddr, MemWriteData;
   logic [31:0] MemReadData;
   logic        MemReadFinish, MemWriteFinish, Busy, ProtocolError;

   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   rd_fin_n = 0, wr_fin_n = 0, rd_exp_n = 0, wr_exp_n = 0;
   exp_t rdq[$];
   exp_t wrq[$];

   data_memory_responder #(
      .MEM_DEPTH_LOG2(10),
      .READ_LATENCY(RL),
      .WRITE_LATENCY(WL)
   ) dut (
      .CLK(clk),
      .Reset(Reset),
      .MemReadStart(MemReadStart),
      .MemReadAddr(MemReadAddr),
      .MemReadData(MemReadData),
      .MemReadFinish(MemReadFinish),
      .MemWriteStart(MemWriteStart),
      .MemWriteAddr(MemWriteAddr),
      .MemWriteData(MemWriteData),
      .MemWriteFinish(MemWriteFinish),
      .Busy(Busy),
      .ProtocolError(ProtocolError)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h (cyc %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic push_rd(input logic [31:0] d, input int due);
      exp_t e;
      e.data = d;
      e.due  = due;
      rdq.push_back(e);
      rd_exp_n++;
   endtask

   task automatic push_wr(input int due);
      exp_t e;
      e.data = 32'd0;
      e.due  = due;
      wrq.push_back(e);
      wr_exp_n++;
   endtask

   task automatic wait_done(input int maxc);
      int n = 0;
      while ((rdq.size() != 0 || wrq.size() != 0) && n < maxc) begin
         @(negedge clk);
         n++;
      end
      if (rdq.size() != 0 || wrq.size() != 0) begin
         chk("timeout", 32'd0, 32'd1);
         rdq.delete();
         wrq.delete();
      end
      @(negedge clk);
   endtask

   // Finish pulses counted cycle by cycle; a pulse with nothing queued is spurious.
   always @(negedge clk) begin
      exp_t e;
      if (MemWriteFinish) begin
         wr_fin_n++;
         if (wrq.size() == 0) chk("wr_spurious", 32'd1, 32'd0);
         else begin
            e = wrq.pop_front();
            chk("wr_cycle", cyc, e.due);
         end
      end
      if (MemReadFinish) begin
         rd_fin_n++;
         if (rdq.size() == 0) chk("rd_spurious", 32'd1, 32'd0);
         else begin
            e = rdq.pop_front();
            chk("rd_cycle", cyc, e.due);
            chk("rd_data", MemReadData, e.data);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cyc %0d", cyc);
      $fatal(1);
   end

   initial begin
      Reset = 1'b1;
      MemReadStart = 1'b0;
      MemWriteStart = 1'b0;
      MemReadAddr = 32'd0;
      MemWriteAddr = 32'd0;
      MemWriteData = 32'd0;
      repeat (3) @(negedge clk);
      chk("rst_rdata", MemReadData, 32'd0);
      chk("rst_rfin", MemReadFinish, 1'b0);
      chk("rst_wfin", MemWriteFinish, 1'b0);
      chk("rst_busy", Busy, 1'b0);
      chk("rst_err", ProtocolError, 1'b0);
      Reset = 1'b0;
      @(negedge clk);

      // Write with Start held high long after completion.
      MemWriteAddr = 32'h0000_0010;
      MemWriteData = 32'hDEAD_BEEF;
      MemWriteStart = 1'b1;
      push_wr(cyc + 1 + WL);
      @(negedge clk);
      chk("busy_wr", Busy, 1'b1);
      wait_done(40);
      repeat (10) @(negedge clk);
      MemWriteStart = 1'b0;
      @(negedge clk);

      // Read back, then confirm the data is held.
      MemReadAddr = 32'h0000_0010;
      MemReadStart = 1'b1;
      push_rd(32'hDEAD_BEEF, cyc + 1 + RL);
      @(negedge clk);
      MemReadStart = 1'b0;
      wait_done(40);
      repeat (20) @(negedge clk);
      chk("rd_hold", MemReadData, 32'hDEAD_BEEF);

      // Simultaneous write and read: write first, read after one idle cycle.
      MemWriteAddr = 32'h0000_0020;
      MemWriteData = 32'h1234_5678;
      MemReadAddr = 32'h0000_0020;
      MemWriteStart = 1'b1;
      MemReadStart = 1'b1;
      push_wr(cyc + 1 + WL);
      push_rd(32'h1234_5678, cyc + 1 + WL + 1 + RL);
      @(negedge clk);
      MemWriteStart = 1'b0;
      MemReadStart = 1'b0;
      chk("busy_simul", Busy, 1'b1);
      wait_done(60);
      chk("err_simul", ProtocolError, 1'b0);

      // Upper address bits alias onto the same word.
      MemReadAddr = 32'h0000_1010;
      MemReadStart = 1'b1;
      push_rd(32'hDEAD_BEEF, cyc + 1 + RL);
      @(negedge clk);
      MemReadStart = 1'b0;
      wait_done(40);

      // Second read edge while reading: flagged and dropped.
      MemReadAddr = 32'h0000_0020;
      MemReadStart = 1'b1;
      push_rd(32'h1234_5678, cyc + 1 + RL);
      @(negedge clk);
      MemReadStart = 1'b0;
      @(negedge clk);
      MemReadStart = 1'b1;
      @(negedge clk);
      chk("err_set", ProtocolError, 1'b1);
      MemReadStart = 1'b0;
      wait_done(40);
      repeat (3) @(negedge clk);
      chk("err_sticky", ProtocolError, 1'b1);

      // Reset in the second WRITE_WAIT cycle loses the write.
      MemWriteAddr = 32'h0000_0040;
      MemWriteData = 32'h5555_5555;
      MemWriteStart = 1'b1;
      push_wr(cyc + 1 + WL);
      @(negedge clk);
      MemWriteStart = 1'b0;
      wait_done(40);
      MemWriteData = 32'hAAAA_AAAA;
      MemWriteStart = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #2 Reset = 1'b1;
      #1;
      chk("arst_rdata", MemReadData, 32'd0);
      chk("arst_rfin", MemReadFinish, 1'b0);
      chk("arst_wfin", MemWriteFinish, 1'b0);
      chk("arst_busy", Busy, 1'b0);
      chk("arst_err", ProtocolError, 1'b0);
      MemWriteStart = 1'b0;
      @(negedge clk);
      @(negedge clk);
      Reset = 1'b0;
      repeat (8) @(negedge clk);
      MemReadAddr = 32'h0000_0040;
      MemReadStart = 1'b1;
      push_rd(32'h5555_5555, cyc + 1 + RL);
      @(negedge clk);
      MemReadStart = 1'b0;
      wait_done(40);

      chk("rd_count", rd_fin_n, rd_exp_n);
      chk("wr_count", wr_fin_n, wr_exp_n);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
